// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and constants for the async FIFO read-side scheduler.
package fifo_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_sched_if.sv
// Request/grant, FIFO read port and tagged output stream of the read scheduler.
interface fifo_rd_sched_if
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int LENW   = 4
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      gnt;
  logic                 fifo_empty;
  logic                 fifo_r_en;
  logic [DWIDTH-1:0]    fifo_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [DWIDTH-1:0]    out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_last;

  modport master (
    input  req, req_len, fifo_empty, fifo_rdata, out_ready,
    output gnt, fifo_r_en, out_valid, out_data, out_id, out_last
  );

  modport slave (
    output req, req_len, fifo_empty, fifo_rdata, out_ready,
    input  gnt, fifo_r_en, out_valid, out_data, out_id, out_last
  );

endinterface

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module fifo_rd_sched_rr_arbiter
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_req
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req[(int'(rr_ptr) + k) % NREQ]) begin
        any_req = 1'b1;
        gnt_idx = IDW'((int'(rr_ptr) + k) % NREQ);
        gnt_oh[(int'(rr_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Shares one FIFO read port between NREQ burst consumers; beats leave through
// a 2-entry skid buffer tagged with owner id and last flag.
//
// state  | meaning
// IDLE   | no grant; arbitrate among pending requests
// BURST  | grant held; issuing FIFO reads while credit and data exist
// FINISH | all reads issued; wait for the last beat to be accepted
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int LENW   = 4
) (
  input logic             rclk,
  input logic             rrst_n,
  fifo_rd_sched_if.master bus
);
  localparam int IDW = id_width(NREQ);

  state_t                state, state_nxt;
  logic [NREQ-1:0]       gnt_q, arb_oh;
  logic [IDW-1:0]        rr_ptr, cur_id, arb_idx, nxt_ptr;
  logic                  arb_any;
  logic [LENW:0]         remaining;
  logic                  inflight, inflight_last;
  logic [1:0]            occ;
  logic                  wr_ptr, rd_ptr;
  logic [DWIDTH-1:0]     buf_data [SKID_DEPTH];
  logic [IDW-1:0]        buf_id   [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] buf_last;
  logic                  valid, pop, credit_ok, r_en, head_last, last_read;
  logic                  grant_now, burst_done;

  fifo_rd_sched_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Credit counts buffered plus in-flight beats, net of this cycle's pop.
  always_comb begin
    valid      = (occ != 2'd0);
    pop        = valid && bus.out_ready;
    credit_ok  = (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
    last_read  = (remaining == (LENW+1)'(1));
    r_en       = (state == BURST) && !bus.fifo_empty && credit_ok && (remaining != '0);
    head_last  = buf_last[rd_ptr];
    burst_done = (state == FINISH) && pop && head_last;
    grant_now  = (state == IDLE) && arb_any;
    nxt_ptr    = (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
    state_nxt  = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = BURST;
      BURST:   if (r_en && last_read) state_nxt = FINISH;
      FINISH:  if (burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gnt_q         <= '0;
      cur_id        <= '0;
      rr_ptr        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= r_en;
      inflight_last <= r_en && last_read;
      if (grant_now) begin
        gnt_q     <= arb_oh;
        cur_id    <= arb_idx;
        remaining <= (LENW+1)'(bus.req_len[arb_idx*LENW +: LENW]) + 1'b1;
      end else if (r_en) begin
        remaining <= remaining - 1'b1;
      end
      if (burst_done) begin
        gnt_q  <= '0;
        rr_ptr <= nxt_ptr;
      end
    end
  end

  // Read data lands one cycle after the read enable; tag it with the owner then.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_id[i]   <= '0;
      end
      buf_last <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= bus.fifo_rdata;
        buf_id[wr_ptr]   <= cur_id;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.fifo_r_en = r_en;
  assign bus.out_valid = valid;
  assign bus.out_data  = buf_data[rd_ptr];
  assign bus.out_id    = buf_id[rd_ptr];
  assign bus.out_last  = valid && head_last;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Self-checking bench: table of burst scenarios plus random ones, checked against
// a round-robin/in-order-FIFO reference model; hand-written mid-burst reset case.
module tb_fifo_rd_sched;
  import fifo_rd_sched_pkg::*;

  localparam int NREQ = 4, DWIDTH = 8, LENW = 4;

  typedef struct {
    bit          rst;
    logic [15:0] cnt;          // bursts per requester, one nibble each
    logic [15:0] lens;         // req_len per requester
    int          ready_mode;   // 0 always, 1 pattern 1,0,0,1, 2 random
    int          stall_after;  // force empty 3 cycles after this read (0 = never)
    int          extra;        // extra FIFO words beyond what the bursts need
    int          exp_first;    // expected first grant id (-1 = skip)
    int          exp_beats;    // expected total beats (-1 = skip)
    int          exp_run;      // expected longest read-enable run (-1 = skip)
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic       last;
  } beat_t;

  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_sched_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .LENW(LENW)) bus ();

  fifo_rd_sched #(.NREQ(NREQ), .DWIDTH(DWIDTH), .LENW(LENW)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  int n_pass = 0, n_chk = 0;
  logic [7:0] fifo_q[$], mdl_data[$];
  beat_t got_beats[$], exp_beats_q[$];
  int got_order[$], exp_order[$];
  int cnt [NREQ];
  int model_ptr, stall, rd_cnt, stall_after, ready_mode, cyc;
  int rd_issued, pops, run, max_run;
  int v_empty, v_out, v_stab, v_gdrop, v_gnt;
  bit pend_rd, prev_hold, prev_last_pop;
  beat_t prev_head;
  logic [3:0] prev_gnt;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic monitor();
    logic [3:0] g;
    bit pop;
    beat_t head;
    g = bus.gnt;
    pop = bus.out_valid && bus.out_ready;
    head = '{bus.out_data, bus.out_id, bus.out_last};
    if (bus.fifo_r_en && bus.fifo_empty) v_empty++;
    if (bus.fifo_r_en) begin
      pend_rd = 1'b1;
      rd_issued++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (prev_hold && !(bus.out_valid && head.data == prev_head.data &&
        head.id == prev_head.id && head.last == prev_head.last)) v_stab++;
    if (prev_last_pop && g != 4'b0) v_gdrop++;
    if (pop) begin
      got_beats.push_back(head);
      pops++;
    end
    if (rd_issued - pops > 2) v_out++;
    if (g != 4'b0 && prev_gnt == 4'b0) begin
      if ($countones(g) != 1) v_gnt++;
      for (int i = 0; i < NREQ; i++)
        if (g[i]) begin
          got_order.push_back(i);
          if (cnt[i] > 0) cnt[i]--;
        end
    end else if (g != 4'b0 && g != prev_gnt) v_gnt++;
    for (int i = 0; i < NREQ; i++) bus.req[i] = (cnt[i] > 0);
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_head = head;
    prev_last_pop = pop && bus.out_last;
    prev_gnt = g;
  endtask

  // FIFO model: a read enabled in one cycle delivers data just after the edge.
  task automatic tick();
    @(posedge rclk);
    #1;
    if (stall > 0) stall--;
    if (pend_rd) begin
      pend_rd = 1'b0;
      if (fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
      rd_cnt++;
      if (rd_cnt == stall_after) stall = 3;
    end
    bus.fifo_empty = (fifo_q.size() == 0) || (stall > 0);
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
    @(negedge rclk);
    monitor();
  endtask

  task automatic clear_tb();
    fifo_q.delete();
    mdl_data.delete();
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    bus.req = '0;
    bus.fifo_empty = 1'b1;
    pend_rd = 1'b0;
    stall = 0;
    rd_issued = 0;
    pops = 0;
    prev_hold = 1'b0;
    prev_last_pop = 1'b0;
    prev_gnt = '0;
    model_ptr = 0;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    clear_tb();
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  // Reference: round-robin over pending burst counts, beats drawn in FIFO order.
  task automatic build_model(input vec_t v);
    int c [NREQ];
    int total, p, len;
    bit found;
    logic [7:0] d;
    exp_order.delete();
    exp_beats_q.delete();
    total = 0;
    for (int i = 0; i < NREQ; i++) c[i] = int'(v.cnt[i*4 +: 4]);
    p = model_ptr;
    do begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++)
        if (!found && c[(p + k) % NREQ] > 0) begin
          found = 1'b1;
          exp_order.push_back((p + k) % NREQ);
          c[(p + k) % NREQ]--;
          total += int'(v.lens[((p + k) % NREQ)*4 +: 4]) + 1;
          p = (p + k + 1) % NREQ;
        end
    end while (found);
    model_ptr = p;
    for (int i = 0; i < total + v.extra; i++) begin
      d = 8'($urandom);
      fifo_q.push_back(d);
      mdl_data.push_back(d);
    end
    foreach (exp_order[j]) begin
      len = int'(v.lens[exp_order[j]*4 +: 4]) + 1;
      for (int b = 0; b < len; b++)
        exp_beats_q.push_back('{mdl_data.pop_front(), 2'(exp_order[j]), (b == len - 1)});
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    bit done;
    if (v.rst) do_reset();
    ready_mode = v.ready_mode;
    stall_after = v.stall_after;
    rd_cnt = 0;
    stall = 0;
    build_model(v);
    got_beats.delete();
    got_order.delete();
    v_empty = 0; v_out = 0; v_stab = 0; v_gdrop = 0; v_gnt = 0;
    run = 0; max_run = 0;
    bus.req_len = v.lens;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = int'(v.cnt[i*4 +: 4]);
      bus.req[i] = (cnt[i] > 0);
    end
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      tick();
      done = (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) && (got_beats.size() >= exp_beats_q.size())
             && (bus.gnt == 4'b0) && !bus.out_valid;
    end
    chk({nm, " done_in_budget"}, 32'(done), 32'd1);
    chk({nm, " grant_count"}, 32'(got_order.size()), 32'(exp_order.size()));
    foreach (exp_order[j])
      if (j < got_order.size()) chk({nm, " grant_order"}, 32'(got_order[j]), 32'(exp_order[j]));
    chk({nm, " beat_count"}, 32'(got_beats.size()), 32'(exp_beats_q.size()));
    foreach (exp_beats_q[j])
      if (j < got_beats.size())
        chk({nm, " beat{data,id,last}"}, {21'b0, got_beats[j].data, got_beats[j].id, got_beats[j].last},
            {21'b0, exp_beats_q[j].data, exp_beats_q[j].id, exp_beats_q[j].last});
    if (v.exp_first >= 0 && got_order.size() > 0)
      chk({nm, " first_grant"}, 32'(got_order[0]), 32'(v.exp_first));
    if (v.exp_beats >= 0) chk({nm, " total_beats"}, 32'(got_beats.size()), 32'(v.exp_beats));
    if (v.exp_run >= 0) chk({nm, " r_en_run"}, 32'(max_run), 32'(v.exp_run));
    chk({nm, " r_en_while_empty"}, 32'(v_empty), 32'd0);
    chk({nm, " outstanding_gt2"}, 32'(v_out), 32'd0);
    chk({nm, " head_unstable"}, 32'(v_stab), 32'd0);
    chk({nm, " gnt_not_dropped"}, 32'(v_gdrop), 32'd0);
    chk({nm, " gnt_not_onehot_held"}, 32'(v_gnt), 32'd0);
  endtask

  initial begin
    vec_t rv;
    bit reached;
    vecs[0] = '{1'b1, 16'h0001, 16'h0003, 0, 0, 6, 0, 4, 4};     // single burst
    vecs[1] = '{1'b0, 16'h0001, 16'h0003, 0, 2, 0, 0, 4, -1};    // empty stall
    vecs[2] = '{1'b0, 16'h0010, 16'h0070, 1, 0, 0, 1, 8, -1};    // backpressure
    vecs[3] = '{1'b1, 16'h1112, 16'h0000, 0, 0, 0, 0, 5, -1};    // round-robin
    vecs[4] = '{1'b1, 16'h0100, 16'h0000, 0, 0, 0, 2, 1, -1};    // leaves rr_ptr=3
    vecs[5] = '{1'b0, 16'h1001, 16'hF002, 0, 0, 0, 3, 19, -1};   // wrap + max length
    vecs[6] = '{1'b0, 16'h2121, 16'h3102, 2, 5, 0, 1, 15, -1};   // mixed, random ready

    bus.req = '0;
    bus.req_len = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    bus.out_ready = 1'b1;
    ready_mode = 0;
    stall_after = 0;
    cyc = 0;
    do_reset();
    chk("reset gnt", 32'(bus.gnt), 32'd0);
    chk("reset fifo_r_en", 32'(bus.fifo_r_en), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_last", 32'(bus.out_last), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_id", 32'(bus.out_id), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      rv.rst = 1'b0;
      for (int i = 0; i < NREQ; i++) rv.cnt[i*4 +: 4] = 4'($urandom_range(0, 2));
      if (rv.cnt == 16'h0) rv.cnt = 16'h0001;
      rv.lens = 16'($urandom);
      rv.ready_mode = int'($urandom_range(0, 2));
      rv.stall_after = int'($urandom_range(0, 6));
      rv.extra = int'($urandom_range(0, 3));
      rv.exp_first = -1;
      rv.exp_beats = -1;
      rv.exp_run = -1;
      run_vec(rv, $sformatf("rand%0d", r));
    end

    // Mid-burst reset: requester 2 again from rr_ptr=3, interrupted at beat 2 of 8.
    run_vec('{1'b0, 16'h0100, 16'h0000, 0, 0, 0, 2, 1, -1}, "pre_rst");
    ready_mode = 0;
    stall_after = 0;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'($urandom));
    bus.req_len = 16'h0700;
    cnt[2] = 1;
    bus.req = 4'b0100;
    got_beats.delete();
    reached = 1'b0;
    for (int t = 0; t < 200 && !reached; t++) begin
      tick();
      reached = (got_beats.size() >= 2);
    end
    chk("rst_seq beat2 reached", 32'(reached), 32'd1);
    chk("rst_seq gnt before reset", 32'(bus.gnt), 32'h4);
    #2 rrst_n = 1'b0;
    #1;
    chk("rst_seq gnt", 32'(bus.gnt), 32'd0);
    chk("rst_seq fifo_r_en", 32'(bus.fifo_r_en), 32'd0);
    chk("rst_seq out_valid", 32'(bus.out_valid), 32'd0);
    clear_tb();
    tick();
    tick();
    rrst_n = 1'b1;
    run_vec('{1'b0, 16'h1001, 16'h0001, 0, 0, 0, 0, 3, -1}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
